// File: rtl/i2s_tx_module.sv
// I2S master transmitter: divides clk_i into BCK/LRCK and serializes stereo
// sample pairs MSB-first, one BCK after each LRCK edge.
module i2s_tx_module #(
   parameter int unsigned FRAME_RES = 32,
   parameter int unsigned DATA_RES  = 24,
   parameter int unsigned BCK_DIV   = 4
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic [DATA_RES-1:0] left_i,
   input  logic [DATA_RES-1:0] right_i,
   input  logic                valid_i,
   output logic                ready_o,
   output logic                bck_o,
   output logic                lrck_o,
   output logic                dat_o,
   output logic                underrun_o
);

   localparam int unsigned DIV_W = (BCK_DIV > 1) ? $clog2(BCK_DIV) : 1;
   localparam int unsigned K_W   = $clog2(2 * FRAME_RES);
   localparam int unsigned K_MAX = 2 * FRAME_RES - 1;

   if (FRAME_RES < 8 || FRAME_RES > 64 || DATA_RES > FRAME_RES - 1 || BCK_DIV < 2) begin : g_bad_params
      $error("i2s_tx_module: illegal parameter set");
   end

   logic [DIV_W-1:0]    div_q;
   logic                bck_q;
   logic                lrck_q;
   logic                dat_q;
   logic                ready_q;
   logic                underrun_q;
   logic                started_q;
   // primed_q low means the next falling edge enters k=0 instead of incrementing
   logic                primed_q;
   logic [K_W-1:0]      k_q;
   logic [DATA_RES-1:0] hold_l_q;
   logic [DATA_RES-1:0] hold_r_q;
   logic [DATA_RES-1:0] sh_l_q;
   logic [DATA_RES-1:0] sh_r_q;

   logic                div_tc;
   logic                fall;
   logic                load;
   logic                xfer;
   logic                right_slot;
   logic                data_slot;
   logic [K_W-1:0]      k_nxt;
   logic [K_W-1:0]      pos;

   // Edge detection and position of the bit about to be driven
   always_comb begin
      div_tc     = 1'b0;
      fall       = 1'b0;
      k_nxt      = '0;
      right_slot = 1'b0;
      pos        = '0;
      data_slot  = 1'b0;
      load       = 1'b0;
      xfer       = 1'b0;

      div_tc = (div_q == DIV_W'(BCK_DIV - 1));
      fall   = div_tc && bck_q;
      if (!primed_q || k_q == K_W'(K_MAX)) begin
         k_nxt = '0;
      end else begin
         k_nxt = k_q + K_W'(1);
      end
      right_slot = (k_nxt >= K_W'(FRAME_RES));
      pos        = right_slot ? (k_nxt - K_W'(FRAME_RES)) : k_nxt;
      data_slot  = (pos >= K_W'(1)) && (pos <= K_W'(DATA_RES));
      load       = fall && (k_nxt == '0);
      xfer       = valid_i && ready_q;
   end

   // BCK divider
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         div_q <= '0;
         bck_q <= 1'b1;
      end else if (div_tc) begin
         div_q <= '0;
         bck_q <= ~bck_q;
      end else begin
         div_q <= div_q + DIV_W'(1);
      end
   end

   // Frame position, LRCK and serial data move only on BCK falling edges
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         k_q      <= '0;
         primed_q <= 1'b0;
         lrck_q   <= 1'b1;
         dat_q    <= 1'b0;
         sh_l_q   <= '0;
         sh_r_q   <= '0;
      end else if (fall) begin
         k_q      <= k_nxt;
         primed_q <= 1'b1;
         lrck_q   <= right_slot;
         dat_q    <= 1'b0;
         if (load) begin
            sh_l_q <= ready_q ? '0 : hold_l_q;
            sh_r_q <= ready_q ? '0 : hold_r_q;
         end else if (data_slot) begin
            if (right_slot) begin
               dat_q  <= sh_r_q[DATA_RES-1];
               sh_r_q <= sh_r_q << 1;
            end else begin
               dat_q  <= sh_l_q[DATA_RES-1];
               sh_l_q <= sh_l_q << 1;
            end
         end
      end
   end

   // Holding register; ready_q doubles as its empty flag
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         ready_q    <= 1'b1;
         started_q  <= 1'b0;
         underrun_q <= 1'b0;
         hold_l_q   <= '0;
         hold_r_q   <= '0;
      end else begin
         underrun_q <= load && ready_q && started_q;
         if (load && !ready_q) begin
            ready_q <= 1'b1;
         end
         if (xfer) begin
            hold_l_q  <= left_i;
            hold_r_q  <= right_i;
            ready_q   <= 1'b0;
            started_q <= 1'b1;
         end
      end
   end

   assign ready_o    = ready_q;
   assign bck_o      = bck_q;
   assign lrck_o     = lrck_q;
   assign dat_o      = dat_q;
   assign underrun_o = underrun_q;

endmodule

// File: tb/tb_i2s_tx_module.sv
// Bench for i2s_tx_module: a serial decoder recovers each slot from BCK rising
// edges and compares it against pairs queued when the handshake accepted them.
module tb_i2s_tx_module;

   localparam int unsigned FRAME_RES = 32;
   localparam int unsigned DATA_RES  = 24;
   localparam int unsigned BCK_DIV   = 2;
   localparam int unsigned FRAME_CLK = 4 * FRAME_RES * BCK_DIV;
   localparam int unsigned BUDGET    = 4 * FRAME_CLK;

   typedef logic [DATA_RES-1:0] word_t;
   typedef struct packed {
      word_t l;
      word_t r;
   } pair_t;

   logic  clk_i   = 1'b0;
   logic  rst_ni  = 1'b0;
   logic  valid_i = 1'b0;
   word_t left_i  = '0;
   word_t right_i = '0;
   logic  ready_o;
   logic  bck_o;
   logic  lrck_o;
   logic  dat_o;
   logic  underrun_o;

   always #5 clk_i = ~clk_i;

   i2s_tx_module #(
      .FRAME_RES (FRAME_RES),
      .DATA_RES  (DATA_RES),
      .BCK_DIV   (BCK_DIV)
   ) u_dut (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .left_i     (left_i),
      .right_i    (right_i),
      .valid_i    (valid_i),
      .ready_o    (ready_o),
      .bck_o      (bck_o),
      .lrck_o     (lrck_o),
      .dat_o      (dat_o),
      .underrun_o (underrun_o)
   );

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   always @(posedge clk_i) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cyc %0d)", tag, got, exp, cyc);
      end
   endtask

   // scoreboard and monitor state
   pair_t hold_q[$];
   pair_t cur        = '0;
   pair_t pend       = '0;
   bit    started_m  = 0;
   bit    xfer_pend  = 0;
   bit    first_fall = 1;
   bit    bp_req     = 0;
   bit    bp_mode    = 0;
   bit    last_xfer_ok = 0;
   logic  bck_prev   = 1'b1;
   logic  lr_prev    = 1'b1;
   logic  dat_prev   = 1'b0;
   logic  dec_lr     = 1'b1;
   bit    dec_act    = 0;
   bit    dec_pad_ok = 1;
   word_t dec_word   = '0;
   int    dec_bi     = 0;
   int    last_fall_cyc = 0;
   int    rel_cyc    = 0;
   int    load_cnt   = 0;
   int    load_cyc   = 0;
   int    uf_cnt     = 0;
   int    n_sent     = 0;
   int    n_xfer     = 0;
   int    ready_hi   = 0;
   int    last_xfer_cyc = 0;

   always @(negedge clk_i) begin
      bit fall;
      bit rise;
      bit load_ev;
      bit exp_uf;
      if (!rst_ni) begin
         hold_q.delete();
         started_m  = 0;
         cur        = '0;
         xfer_pend  = 0;
         bck_prev   = 1'b1;
         lr_prev    = 1'b1;
         dat_prev   = 1'b0;
         first_fall = 1;
         dec_act    = 0;
         dec_lr     = 1'b1;
         dec_bi     = 0;
      end else begin
         fall    = bck_prev && !bck_o;
         rise    = !bck_prev && bck_o;
         load_ev = fall && lr_prev && !lrck_o;
         exp_uf  = 0;

         if (lrck_o != lr_prev || dat_o != dat_prev) chk("edge_align", 64'(fall), 64'd1);

         if (fall) begin
            if (first_fall) chk("first_fall", 64'(cyc - rel_cyc), 64'(BCK_DIV));
            else            chk("bck_period", 64'(cyc - last_fall_cyc), 64'(2 * BCK_DIV));
            first_fall    = 0;
            last_fall_cyc = cyc;
         end

         // left-slot start: the oldest accepted pair goes on air, else zeros
         if (load_ev) begin
            exp_uf = (hold_q.size() == 0) && started_m;
            if (hold_q.size() != 0) cur = hold_q.pop_front();
            else                    cur = '0;
            if (bp_mode) chk("bp_ready", 64'(ready_hi <= 1), 64'd1);
            ready_hi = 0;
            load_cnt++;
            load_cyc = cyc;
            if (bp_req) begin
               bp_mode      = 1;
               last_xfer_ok = 0;
            end
         end
         if (load_ev || underrun_o) chk("underrun", 64'(underrun_o), 64'(exp_uf));
         if (underrun_o) uf_cnt++;

         if (xfer_pend) begin
            hold_q.push_back(pend);
            started_m = 1;
            n_xfer++;
            if (bp_mode) begin
               if (last_xfer_ok) chk("bp_spacing", 64'(cyc - last_xfer_cyc), 64'(FRAME_CLK));
               last_xfer_cyc = cyc;
               last_xfer_ok  = 1;
            end
         end
         xfer_pend = valid_i && ready_o;
         pend      = {left_i, right_i};
         if (ready_o) ready_hi++;

         // receiver side: sample on BCK rising edges
         if (rise) begin
            if (lrck_o != dec_lr) begin
               if (dec_act) chk("slot_len", 64'(dec_bi), 64'(FRAME_RES - 1));
               dec_act    = 1;
               dec_lr     = lrck_o;
               dec_bi     = 0;
               dec_word   = '0;
               dec_pad_ok = (dat_o == 1'b0);
            end else begin
               dec_bi++;
               if (dec_bi >= 1 && dec_bi <= int'(DATA_RES)) dec_word = {dec_word[DATA_RES-2:0], dat_o};
               else if (dat_o) dec_pad_ok = 0;
            end
            if (dec_act && dec_bi == int'(FRAME_RES - 1)) begin
               chk(dec_lr ? "right_word" : "left_word", 64'(dec_word), 64'(dec_lr ? cur.r : cur.l));
               chk("pad_zero", 64'(dec_pad_ok), 64'd1);
            end
         end

         bck_prev = bck_o;
         lr_prev  = lrck_o;
         dat_prev = dat_o;
      end
   end

   task automatic send(input word_t l, input word_t r, input bit keep);
      int t = 0;
      @(posedge clk_i); #1;
      left_i  = l;
      right_i = r;
      valid_i = 1'b1;
      @(negedge clk_i);
      while (!ready_o && t < int'(BUDGET)) begin
         @(negedge clk_i);
         t++;
      end
      chk("send_wait", 64'(ready_o), 64'd1);
      @(posedge clk_i); #1;
      n_sent++;
      if (!keep) valid_i = 1'b0;
   endtask

   task automatic wait_load();
      int n = load_cnt;
      int t = 0;
      while (load_cnt == n && t < int'(BUDGET)) begin
         @(negedge clk_i); #1;
         t++;
      end
      chk("load_wait", 64'(load_cnt != n), 64'd1);
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_bck"},   64'(bck_o),      64'd1);
      chk({tag, "_lrck"},  64'(lrck_o),     64'd1);
      chk({tag, "_dat"},   64'(dat_o),      64'd0);
      chk({tag, "_ready"}, 64'(ready_o),    64'd1);
      chk({tag, "_uf"},    64'(underrun_o), 64'd0);
   endtask

   initial begin
      #(FRAME_CLK * 10 * 200);
      $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
      $fatal(1);
   end

   initial begin
      int u0;
      repeat (3) @(posedge clk_i);
      #1;
      check_reset_outputs("rst");
      rst_ni  = 1'b1;
      rel_cyc = cyc;

      // idle frames before any transfer must not flag underrun
      wait_load();
      wait_load();
      chk("no_uf_before_xfer", 64'(uf_cnt), 64'd0);

      // basic frame
      send(24'hA50F3C, 24'h800001, 1'b0);
      wait_load();
      wait_load();

      // loopback stream
      send(24'h123456, 24'h654321, 1'b0);
      send(24'hFFFFFF, 24'h000000, 1'b0);
      send(24'h800000, 24'h7FFFFF, 1'b0);

      // back-pressure with valid held high
      bp_req = 1;
      for (int i = 0; i < 6; i++) begin
         send(word_t'(24'h100000 + i), word_t'(24'h200000 + i), i < 5);
      end
      bp_req  = 0;
      bp_mode = 0;

      // underrun: one pair, then two idle frames
      wait_load();
      wait_load();
      u0 = uf_cnt;
      send(24'h0F0F0F, 24'hF0F0F0, 1'b0);
      wait_load();
      wait_load();
      wait_load();
      chk("uf_two_frames", 64'(uf_cnt - u0), 64'd2);

      // valid on the exact clk of a load with holding empty
      while (cyc < load_cyc + int'(FRAME_CLK) - 1) begin
         @(posedge clk_i); #1;
      end
      left_i  = 24'h5A5A5A;
      right_i = 24'hC3C3C3;
      valid_i = 1'b1;
      @(posedge clk_i); #1;
      n_sent++;
      valid_i = 1'b0;
      chk("simul_uf", 64'(underrun_o), 64'd1);
      wait_load();
      wait_load();

      // reset in the right slot at k=40 with a pair held
      send(24'h000000, 24'hFFFFFF, 1'b0);
      wait_load();
      send(24'h123456, 24'hABCDEF, 1'b0);
      while (cyc < load_cyc + 161) begin
         @(posedge clk_i); #1;
      end
      rst_ni = 1'b0;
      #1;
      check_reset_outputs("mid_rst");
      u0 = uf_cnt;
      repeat (3) @(posedge clk_i);
      #1;
      rst_ni  = 1'b1;
      rel_cyc = cyc;
      wait_load();
      wait_load();
      chk("uf_after_rst", 64'(uf_cnt - u0), 64'd0);
      chk("xfer_count", 64'(n_xfer), 64'(n_sent));
      chk("hold_empty", 64'(hold_q.size()), 64'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
